x7seg_scan: RTL and testbench
=============================

Name: x7seg_scan

Overview:
- Parametrised multiplexed seven-segment driver for N hex digits. Successor to the fixed 4-digit combinational scanner.
- Adds:
  - a built-in refresh prescaler;
  - a frame-snapshot of the display value, so no tearing occurs mid-scan;
  - per-digit decimal points;
  - generalised leading-zero blanking.
- Sits between the game score/debug registers and the board's common-anode display pins.

Parameters:
- DIGITS, 4, number of digits scanned (1..8).
- DIV, 50000, cclk cycles per digit slot (>=2). Prescaler width is clog2(DIV).
- LZB_DEFAULT, 1, reset value of the internal blanking-enable register.

Ports:
- cclk  in  1  system clock; all state is updated on its rising edge.
- clr  in  1  asynchronous, active-high reset.
- value  in  4*DIGITS  hex nibbles; digit i = value[4i+3:4i], digit 0 = rightmost.
- dp_in  in  DIGITS  decimal-point request per digit, active-high.
- lzb_set  in  1  one-cycle pulse: load lzb_val into the blanking-enable register.
- lzb_val  in  1  new blanking enable.
- a_to_g  out  7  segments a..g (bit6 = a), active-low.
- an  out  DIGITS  digit anodes, active-low, one-hot-low when lit.
- dp  out  1  decimal point, active-low.
- frame  out  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset (clr high, asynchronous):
  - prescaler = 0, idx = 0;
  - snapshot value = 0, snapshot dp = 0, lzb = LZB_DEFAULT;
  - a_to_g = 7'b1111111, an = all ones, dp = 1, frame = 0.
  - Reset mid-scan blanks all outputs immediately.
- Prescaler counts 0..DIV-1 and wraps. tick = (prescaler == DIV-1).
- On tick: idx <= (idx == DIGITS-1) ? 0 : idx+1.
- On tick with idx == DIGITS-1 (frame wrap):
  - snap_val <= value, snap_dp <= dp_in;
  - frame <= 1 for exactly one cycle.
  - The first snapshot after reset occurs at the first frame wrap. Until then, snap = 0, so digit 0 shows "0".
- Outputs are registered from (idx, snap_val, snap_dp, lzb), so they lag idx by one cycle.
- Segment code is the standard active-low hex font:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111;
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Leading-zero blanking:
  - Digit i is blanked iff lzb==1, i != 0, and snap nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never blanked.
  - Blanked slot: an all ones, a_to_g = 1111111, dp = 1, even if snap_dp[i]=1.
- Lit slot: an[idx] = 0, all other an bits = 1; dp = ~snap_dp[idx].
- lzb_set takes effect on the next clock edge. The new setting applies to the very next registered output, not deferred to the frame.
- value/dp_in changes between frame wraps are invisible until the next wrap.
- DIGITS == 1: idx stays 0, and every tick is a frame wrap.

Optional Feature:
- Macro: X7SEG_BLINK_EN.
- Enabled:
  - Adds input blink_mask[DIGITS-1:0] (snapshotted with value) and parameter BLINK_FRAMES (default 32).
  - A frame counter toggles a blink phase every BLINK_FRAMES frames. Phase resets to 0 (visible).
  - While phase==1, masked digits are output as blanked.
- Disabled: no port, no counter; behaviour exactly as above.

Decomposition:
- Package x7seg_pkg holds:
  - the 16-entry active-low segment font constant;
  - SEG_OFF = 7'b1111111;
  - a function hex_to_seg(nibble).
- One natural sub-module, x7seg_prescaler (generic tick divider, parameter DIV, ports cclk/clr/tick). It is reused by other timers in the design.

Test Plan:
- Reset and first frame:
  - Setup: DIGITS=4, DIV=4. Hold clr 3 cycles, release.
  - Required: an=1111, a_to_g=1111111, dp=1 during reset.
  - Required: after release, first lit slot is digit 0 showing 0000001 with an=1110 (lzb=1, snap=0).
- Scan order and tick:
  - Stimulus: value=16'h1234, dp_in=0, lzb=0, DIV=4.
  - Required: after the first frame pulse, each digit is held for 4 cycles, in order:
    - an=1110/a_to_g=1001100;
    - an=1101/0000110;
    - an=1011/0010010;
    - an=0111/1001111;
    - then wraps.
- Leading-zero blanking:
  - Stimulus: value=16'h0050, lzb=1.
  - Required: digits 3 and 2 show an=1111. Digit 1 shows 5 (0100100). Digit 0 shows 0 (0000001).
  - Stimulus: value=0.
  - Required: only digit 0 is lit.
- Snapshot isolation:
  - Stimulus: change value from 16'h1111 to 16'h2222 while idx=1.
  - Required: digits 2,3 of the current frame still show 1. Digit 2 appears only after the next frame pulse.
- Decimal point with blanking:
  - Stimulus: dp_in=4'b1001, value=16'h0007, lzb=1.
  - Required: digit 0 shows dp=0. Digit 3 stays fully dark with dp=1.
- Blink (X7SEG_BLINK_EN defined):
  - Stimulus: BLINK_FRAMES=2, blink_mask=4'b0001, value=16'h0008.
  - Required: digit 0 is lit for 2 frames, then dark for 2 frames, repeating.

Source files
------------

// File: rtl/x7seg_pkg.sv
// x7seg_pkg: shared segment font and helpers for the seven-segment scanner.
// Segment order is {a,b,c,d,e,f,g}, active-low (0 lights the segment).
package x7seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Entry n is the glyph for hex digit n (0..F).
  localparam logic [15:0][6:0] SEG_FONT = {
    7'b0111000,  // F
    7'b0110000,  // E
    7'b1000010,  // d
    7'b0110001,  // C
    7'b1100000,  // b
    7'b0001000,  // A
    7'b0000100,  // 9
    7'b0000000,  // 8
    7'b0001111,  // 7
    7'b0100000,  // 6
    7'b0100100,  // 5
    7'b1001100,  // 4
    7'b0000110,  // 3
    7'b0010010,  // 2
    7'b1001111,  // 1
    7'b0000001   // 0
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    return SEG_FONT[nib];
  endfunction

endpackage

// File: rtl/x7seg_prescaler.sv
// x7seg_prescaler: free-running divider, tick is high for one cycle every DIV
// cycles (when the count sits at DIV-1). Shared with other timers.
module x7seg_prescaler #(
  parameter int DIV = 50000
) (
  input  logic cclk,
  input  logic clr,
  output logic tick
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] cnt;

  assign tick = (cnt == PW'(DIV - 1));

  // Count 0..DIV-1 and wrap.
  always_ff @(posedge cclk or posedge clr) begin
    if (clr)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + PW'(1);
  end

endmodule

// File: rtl/x7seg_scan.sv
// x7seg_scan: multiplexed N-digit hex driver for common-anode displays.
// The display value is snapshotted once per frame (after the last digit slot)
// so a scan never mixes two values. Outputs are registered and trail idx by
// one cycle. Optional blinking is built when X7SEG_BLINK_EN is defined.
module x7seg_scan
  import x7seg_pkg::*;
#(
  parameter int DIGITS      = 4,
  parameter int DIV         = 50000,
  parameter bit LZB_DEFAULT = 1'b1
`ifdef X7SEG_BLINK_EN
  ,
  parameter int BLINK_FRAMES = 32
`endif
) (
  input  logic                  cclk,
  input  logic                  clr,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  lzb_set,
  input  logic                  lzb_val,
`ifdef X7SEG_BLINK_EN
  input  logic [DIGITS-1:0]     blink_mask,
`endif
  output logic [6:0]            a_to_g,
  output logic [DIGITS-1:0]     an,
  output logic                  dp,
  output logic                  frame
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic                tick;
  logic [IW-1:0]       idx;
  logic                last;
  logic                wrap;
  logic [4*DIGITS-1:0] snap_val;
  logic [DIGITS-1:0]   snap_dp;
  logic                lzb;
  logic [DIGITS-1:0]   zero_up;   // nibbles i..DIGITS-1 of the snapshot are all zero
  logic [DIGITS-1:0]   blank;     // digit i renders dark this frame
  logic [3:0]          nib;

  x7seg_prescaler #(.DIV(DIV)) u_pre (
    .cclk (cclk),
    .clr  (clr),
    .tick (tick)
  );

  assign last = (idx == IW'(DIGITS - 1));
  assign wrap = tick & last;
  assign nib  = snap_val[idx*4 +: 4];

`ifdef X7SEG_BLINK_EN
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [BW-1:0]     fcnt;
  logic              phase;
  logic [DIGITS-1:0] snap_mask;

  // Count frame wraps; flip the blink phase every BLINK_FRAMES of them.
  always_ff @(posedge cclk or posedge clr) begin
    if (clr) begin
      fcnt      <= '0;
      phase     <= 1'b0;
      snap_mask <= '0;
    end else if (wrap) begin
      snap_mask <= blink_mask;
      if (fcnt == BW'(BLINK_FRAMES - 1)) begin
        fcnt  <= '0;
        phase <= ~phase;
      end else begin
        fcnt  <= fcnt + BW'(1);
      end
    end
  end
`endif

  // Digit slot index advances on each prescaler tick.
  always_ff @(posedge cclk or posedge clr) begin
    if (clr)       idx <= '0;
    else if (tick) idx <= last ? '0 : idx + IW'(1);
  end

  // Frame snapshot: value and decimal points latch only at the frame wrap.
  always_ff @(posedge cclk or posedge clr) begin
    if (clr) begin
      snap_val <= '0;
      snap_dp  <= '0;
    end else if (wrap) begin
      snap_val <= value;
      snap_dp  <= dp_in;
    end
  end

  // Blanking enable; a set pulse is visible on the very next output update.
  always_ff @(posedge cclk or posedge clr) begin
    if (clr)          lzb <= LZB_DEFAULT;
    else if (lzb_set) lzb <= lzb_val;
  end

  // Per-digit blanking: leading zeros (never digit 0), plus blink if built.
  always_comb begin
    logic acc;
    acc     = 1'b1;
    zero_up = '0;
    blank   = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc        = acc && (snap_val[4*i +: 4] == 4'h0);
      zero_up[i] = acc;
      blank[i]   = lzb && (i != 0) && zero_up[i];
`ifdef X7SEG_BLINK_EN
      blank[i]   = blank[i] || (phase && snap_mask[i]);
`endif
    end
  end

  // Registered pin drive for the current slot and the frame pulse.
  always_ff @(posedge cclk or posedge clr) begin
    if (clr) begin
      an     <= '1;
      a_to_g <= SEG_OFF;
      dp     <= 1'b1;
      frame  <= 1'b0;
    end else begin
      frame <= wrap;
      if (blank[idx]) begin
        an     <= '1;
        a_to_g <= SEG_OFF;
        dp     <= 1'b1;
      end else begin
        an     <= ~(DIGITS'(1) << idx);
        a_to_g <= hex_to_seg(nib);
        dp     <= ~snap_dp[idx];
      end
    end
  end

endmodule

// File: tb/tb_x7seg_scan.sv
// tb_x7seg_scan: directed phases from the test plan plus random traffic,
// checked every cycle against a cycle-count based model of the scanner.
module tb_x7seg_scan;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;

  logic        cclk = 1'b0;
  logic        clr  = 1'b1;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic        lzb_set = 1'b0;
  logic        lzb_val = 1'b0;
`ifdef X7SEG_BLINK_EN
  logic [3:0]  blink_mask = '0;
`endif
  logic [6:0]  a_to_g;
  logic [3:0]  an;
  logic        dp;
  logic        frame;

  always #5 cclk = ~cclk;

  x7seg_scan #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .cclk    (cclk),
    .clr     (clr),
    .value   (value),
    .dp_in   (dp_in),
    .lzb_set (lzb_set),
    .lzb_val (lzb_val),
`ifdef X7SEG_BLINK_EN
    .blink_mask (blink_mask),
`endif
    .a_to_g  (a_to_g),
    .an      (an),
    .dp      (dp),
    .frame   (frame)
  );

  logic [6:0] font [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  int n_tests = 0;
  int n_fail  = 0;

  // Model state: edges since reset release, the frame snapshot and blanking.
  int          n;
  logic [15:0] m_snap;
  logic [3:0]  m_dp;
  logic        m_lzb;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    n      = 0;
    m_snap = '0;
    m_dp   = '0;
    m_lzb  = 1'b1;
  endtask

  // One clock: predict {an,a_to_g,dp,frame} for this edge, then apply the
  // edge's snapshot / blanking updates to the model.
  task automatic step(input string tag);
    int          idx;
    logic        wrap;
    logic [3:0]  nib;
    logic [3:0]  one;
    logic [3:0]  an_e;
    logic [12:0] e;
    @(posedge cclk);
    n++;
    idx  = ((n - 1) / DIV) % DIGITS;
    wrap = ((n % FRAME) == 0);
    one  = 4'b0001;
    if (m_lzb && idx != 0 && (m_snap >> (4 * idx)) == 16'h0) begin
      e = {4'hf, 7'h7f, 1'b1, wrap};
    end else begin
      nib  = m_snap[4*idx +: 4];
      an_e = ~(one << idx);
      e    = {an_e, font[nib], ~m_dp[idx], wrap};
    end
    if (wrap) begin
      m_snap = value;
      m_dp   = dp_in;
    end
    if (lzb_set) m_lzb = lzb_val;
    #1;
    chk(tag, {an, a_to_g, dp, frame}, e);
    lzb_set = 1'b0;
  endtask

  task automatic run(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) step(tag);
  endtask

  task automatic rand_run(input string tag, input int cycles);
    logic [15:0] masks [5];
    masks = '{16'hffff, 16'h0fff, 16'h00ff, 16'h000f, 16'h0000};
    for (int i = 0; i < cycles; i++) begin
      if ($urandom_range(3) == 0) value = 16'($urandom) & masks[$urandom_range(4)];
      if ($urandom_range(3) == 0) dp_in = 4'($urandom);
      if ($urandom_range(7) == 0) begin
        lzb_set = 1'b1;
        lzb_val = 1'($urandom);
      end
      step(tag);
    end
  endtask

  initial begin
    // Reset held three cycles: everything dark.
    for (int i = 0; i < 3; i++) begin
      @(negedge cclk);
      chk("reset_dark", {an, a_to_g, dp, frame}, {4'hf, 7'h7f, 1'b1, 1'b0});
    end
    @(posedge cclk);
    #1 clr = 1'b0;
    model_reset();

    // First frame shows digit 0 as "0", upper digits blanked.
    run("first_frame", FRAME + 2);

    // Scan order with blanking off.
    value = 16'h1234; dp_in = 4'h0; lzb_set = 1'b1; lzb_val = 1'b0;
    run("scan_1234", 3 * FRAME);

    // Leading-zero blanking.
    value = 16'h0050; lzb_set = 1'b1; lzb_val = 1'b1;
    run("lzb_0050", 3 * FRAME);
    value = 16'h0000;
    run("lzb_zero", 2 * FRAME);

    // Snapshot isolation: change value while idx == 1.
    value = 16'h1111;
    run("snap_1111", 2 * FRAME);
    for (int i = 0; i < FRAME && ((n / DIV) % DIGITS) != 1; i++) step("snap_align");
    value = 16'h2222;
    run("snap_2222", 3 * FRAME);

    // Decimal points with blanking.
    dp_in = 4'b1001; value = 16'h0007; lzb_set = 1'b1; lzb_val = 1'b1;
    run("dp_lzb", 3 * FRAME);

    rand_run("rand_a", 400);

    // Asynchronous reset mid-scan blanks the pins at once.
    #2 clr = 1'b1;
    #1 chk("async_rst", {an, a_to_g, dp, frame}, {4'hf, 7'h7f, 1'b1, 1'b0});
    @(negedge cclk);
    chk("rst_hold", {an, a_to_g, dp, frame}, {4'hf, 7'h7f, 1'b1, 1'b0});
    @(posedge cclk);
    #1 clr = 1'b0;
    model_reset();
    value = 16'h00a0;
    run("after_rst", 2 * FRAME);

    rand_run("rand_b", 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
